// File: rtl/bp_pkg.sv
// Shared constants for the branch predictor: 2-bit counter encodings and index modes.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt2_t;

  localparam int MODE_BIMODAL = 0;
  localparam int MODE_GSHARE  = 1;

endpackage

// File: rtl/bp_sat_counter2.sv
// Combinational next-state for a 2-bit saturating taken/not-taken counter.
module bp_sat_counter2
  import bp_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       taken,
  output logic [1:0] next
);

  always_comb begin
    next = cnt;
    if (taken) begin
      if (cnt != ST) next = cnt + 2'd1;
    end else begin
      if (cnt != SNT) next = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predict_gshare.sv
// Gshare/bimodal direction predictor: 2-bit counter PHT, speculative global history
// with mispredict repair, decode-stage prediction register and perf counters.
module branch_predict_gshare
  import bp_pkg::*;
#(
  parameter int PHT_DEPTH = 10,
  parameter int GHR_WIDTH = 10,
  parameter int MODE      = MODE_GSHARE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stallD,
  input  logic                 flushD,
  input  logic [31:0]          pcF,
  input  logic                 branchF,
  output logic                 pred_takeF,
  output logic [PHT_DEPTH-1:0] pred_indexF,
  output logic [GHR_WIDTH-1:0] ghr_snapF,
  input  logic                 branchD,
  output logic                 pred_takeD,
  input  logic                 branchM,
  input  logic                 actual_takeM,
  input  logic                 pred_takeM,
  input  logic [PHT_DEPTH-1:0] update_indexM,
  input  logic [GHR_WIDTH-1:0] ghr_snapM,
  output logic [31:0]          branch_cnt,
  output logic [31:0]          mispred_cnt
);

  localparam int unsigned PHT_SIZE = 1 << PHT_DEPTH;

  logic [1:0]           pht [PHT_SIZE];
  logic [GHR_WIDTH-1:0] ghr;
  logic [PHT_DEPTH-1:0] pcIdx;
  logic [PHT_DEPTH-1:0] ghrExt;
  logic [GHR_WIDTH-1:0] specHist;
  logic [GHR_WIDTH-1:0] fixHist;
  logic [1:0]           cntNext;
  logic                 predTakeR;
  logic                 mispred;
  logic                 fetchShift;
  logic                 unusedBits;

  assign unusedBits = ^{pcF[31:PHT_DEPTH+2], pcF[1:0], ghr_snapM};

  assign pcIdx       = pcF[PHT_DEPTH+1:2];
  assign ghrExt      = PHT_DEPTH'(ghr);
  assign pred_indexF = (MODE == MODE_GSHARE) ? (pcIdx ^ ghrExt) : pcIdx;
  assign pred_takeF  = pht[pred_indexF][1];
  assign ghr_snapF   = ghr;
  assign pred_takeD  = branchD & predTakeR;

  assign mispred    = branchM & (actual_takeM ^ pred_takeM);
  assign fetchShift = branchF & ~stallD & ~flushD;

  // A 1-bit history has no bits to shift out, so it just takes the new outcome.
  if (GHR_WIDTH == 1) begin : gHist1
    assign specHist = pred_takeF;
    assign fixHist  = actual_takeM;
  end else begin : gHistN
    assign specHist = {ghr[GHR_WIDTH-2:0], pred_takeF};
    assign fixHist  = {ghr_snapM[GHR_WIDTH-2:0], actual_takeM};
  end

  bp_sat_counter2 uCnt (
    .cnt   (pht[update_indexM]),
    .taken (actual_takeM),
    .next  (cntNext)
  );

  // Fetch reads the pre-write entry on a same-index collision since the write is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < PHT_SIZE; i++) pht[i[PHT_DEPTH-1:0]] <= WNT;
    end else if (branchM) begin
      pht[update_indexM] <= cntNext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)             ghr <= '0;
    else if (mispred)    ghr <= fixHist;
    else if (fetchShift) ghr <= specHist;
  end

  always_ff @(posedge clk) begin
    if (rst)          predTakeR <= 1'b0;
    else if (flushD)  predTakeR <= 1'b0;
    else if (!stallD) predTakeR <= pred_takeF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (branchM && branch_cnt != '1) branch_cnt  <= branch_cnt + 32'd1;
      if (mispred && mispred_cnt != '1) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predict_gshare.sv
// Self-checking bench for branch_predict_gshare against an array-based reference model.
module tb_branch_predict_gshare;

  logic        clk, rst, stallD, flushD, branchF, branchD, branchM, actual_takeM, pred_takeM;
  logic [31:0] pcF;
  logic [9:0]  update_indexM, ghr_snapM;
  logic        pred_takeF, pred_takeD;
  logic [9:0]  pred_indexF, ghr_snapF;
  logic [31:0] branch_cnt, mispred_cnt;
  logic        b_pred_takeF, b_pred_takeD;
  logic [9:0]  b_pred_indexF, b_ghr_snapF;
  logic [31:0] b_branch_cnt, b_mispred_cnt;

  int checks = 0;
  int errors = 0;

  int     mPht [1024];
  int     mGhr;
  bit     mPtr;
  longint mB, mM;

  branch_predict_gshare #(.PHT_DEPTH(10), .GHR_WIDTH(10), .MODE(1)) dut (
    .clk(clk), .rst(rst), .stallD(stallD), .flushD(flushD), .pcF(pcF), .branchF(branchF),
    .pred_takeF(pred_takeF), .pred_indexF(pred_indexF), .ghr_snapF(ghr_snapF),
    .branchD(branchD), .pred_takeD(pred_takeD), .branchM(branchM), .actual_takeM(actual_takeM),
    .pred_takeM(pred_takeM), .update_indexM(update_indexM), .ghr_snapM(ghr_snapM),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  branch_predict_gshare #(.PHT_DEPTH(10), .GHR_WIDTH(10), .MODE(0)) dutB (
    .clk(clk), .rst(rst), .stallD(stallD), .flushD(flushD), .pcF(pcF), .branchF(branchF),
    .pred_takeF(b_pred_takeF), .pred_indexF(b_pred_indexF), .ghr_snapF(b_ghr_snapF),
    .branchD(branchD), .pred_takeD(b_pred_takeD), .branchM(branchM), .actual_takeM(actual_takeM),
    .pred_takeM(pred_takeM), .update_indexM(update_indexM), .ghr_snapM(ghr_snapM),
    .branch_cnt(b_branch_cnt), .mispred_cnt(b_mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int m_index(input logic [31:0] pc);
    return ((pc >> 2) & 32'h3FF) ^ mGhr;
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return mPht[m_index(pc)] >= 2;
  endfunction

  function automatic void model_step();
    int idx, u;
    bit pf, mis;
    if (rst) begin
      foreach (mPht[i]) mPht[i] = 1;
      mGhr = 0; mPtr = 0; mB = 0; mM = 0;
      return;
    end
    idx = m_index(pcF);
    pf  = mPht[idx] >= 2;
    mis = branchM && (actual_takeM != pred_takeM);
    u   = int'(update_indexM);
    if (branchM) mPht[u] = actual_takeM ? ((mPht[u] < 3) ? mPht[u] + 1 : 3)
                                        : ((mPht[u] > 0) ? mPht[u] - 1 : 0);
    if (mis) mGhr = ((int'(ghr_snapM) << 1) | int'(actual_takeM)) & 32'h3FF;
    else if (branchF && !stallD && !flushD) mGhr = ((mGhr << 1) | int'(pf)) & 32'h3FF;
    if (flushD) mPtr = 0;
    else if (!stallD) mPtr = pf;
    if (branchM && mB < 64'hFFFF_FFFF) mB++;
    if (mis && mM < 64'hFFFF_FFFF) mM++;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    stallD = 0; flushD = 0; branchF = 0; branchD = 0; branchM = 0;
    actual_takeM = 0; pred_takeM = 0; update_indexM = '0; ghr_snapM = '0; pcF = '0;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1; pcF = 32'h100;
    branchF = 1; branchM = 1; actual_takeM = 1; pred_takeM = 0;
    ghr_snapM = 10'h3FF; update_indexM = 10'h40;
    tick(); tick();
    rst = 0; set_idle(); pcF = 32'h100; branchD = 1;
    #1;
    checks++; if (pred_takeF !== 1'b0) begin errors++; $display("FAIL reset_predF got %b exp 0", pred_takeF); end
    checks++; if (ghr_snapF !== 10'h000) begin errors++; $display("FAIL reset_ghr got %h exp 000", ghr_snapF); end
    checks++; if (branch_cnt !== 32'd0) begin errors++; $display("FAIL reset_bcnt got %h exp 0", branch_cnt); end
    checks++; if (mispred_cnt !== 32'd0) begin errors++; $display("FAIL reset_mcnt got %h exp 0", mispred_cnt); end
    checks++; if (pred_takeD !== 1'b0) begin errors++; $display("FAIL reset_predD got %b exp 0", pred_takeD); end
    for (int k = 0; k < 8; k++) begin
      pcF = $urandom();
      #1;
      checks++; if (pred_takeF !== 1'b0) begin errors++; $display("FAIL untrained_predF pc %h got %b exp 0", pcF, pred_takeF); end
    end
    tick();
  endtask

  task automatic test_train();
    set_idle();
    pcF = 32'h100;
    branchM = 1; update_indexM = 10'h40; actual_takeM = 1; pred_takeM = 1;
    #1;
    checks++; if (pred_indexF !== 10'h040) begin errors++; $display("FAIL train_index got %h exp 040", pred_indexF); end
    tick();
    checks++; if (pred_takeF !== 1'b1) begin errors++; $display("FAIL train_wt got %b exp 1", pred_takeF); end
    tick();
    actual_takeM = 0; pred_takeM = 0;
    tick();
    checks++; if (pred_takeF !== 1'b1) begin errors++; $display("FAIL train_st_to_wt got %b exp 1", pred_takeF); end
    tick();
    checks++; if (pred_takeF !== 1'b0) begin errors++; $display("FAIL train_wnt got %b exp 0", pred_takeF); end
    // same-cycle read and write of one entry returns the old value
    actual_takeM = 1; pred_takeM = 1;
    #1;
    checks++; if (pred_takeF !== 1'b0) begin errors++; $display("FAIL rbw_predF got %b exp 0", pred_takeF); end
    tick();
    actual_takeM = 0; pred_takeM = 0;
    tick();
    checks++; if (branch_cnt !== mB[31:0]) begin errors++; $display("FAIL train_bcnt got %h exp %h", branch_cnt, mB[31:0]); end
    checks++; if (mispred_cnt !== 32'd0) begin errors++; $display("FAIL train_mcnt got %h exp 0", mispred_cnt); end
  endtask

  task automatic test_ghr_mispred_priority();
    set_idle();
    branchM = 1; update_indexM = 10'h0B0; actual_takeM = 1; pred_takeM = 1;
    tick(); tick();
    actual_takeM = 0; pred_takeM = 1; ghr_snapM = 10'h078; update_indexM = 10'h3FF;
    tick();
    set_idle();
    #1;
    checks++; if (ghr_snapF !== 10'h0F0) begin errors++; $display("FAIL ghr_repair got %h exp 0F0", ghr_snapF); end
    pcF = 32'h100; branchF = 1;
    branchM = 1; actual_takeM = 0; pred_takeM = 1; ghr_snapM = 10'h003; update_indexM = 10'h3FF;
    #1;
    checks++; if (pred_takeF !== 1'b1) begin errors++; $display("FAIL prio_predF got %b exp 1", pred_takeF); end
    tick();
    checks++; if (ghr_snapF !== 10'h006) begin errors++; $display("FAIL prio_ghr got %h exp 006", ghr_snapF); end
    set_idle();
    pcF = 32'h100; branchF = 1;
    #1;
    tick();
    checks++; if (ghr_snapF !== mGhr[9:0]) begin errors++; $display("FAIL spec_shift got %h exp %h", ghr_snapF, mGhr[9:0]); end
  endtask

  task automatic test_mode_index();
    set_idle();
    branchM = 1; actual_takeM = 1; pred_takeM = 0; ghr_snapM = 10'h1FF; update_indexM = 10'h3FF;
    tick();
    set_idle();
    pcF = 32'h0000_0404;
    #1;
    checks++; if (ghr_snapF !== 10'h3FF) begin errors++; $display("FAIL mode_ghr got %h exp 3FF", ghr_snapF); end
    checks++; if (b_pred_indexF !== 10'h101) begin errors++; $display("FAIL bimodal_index got %h exp 101", b_pred_indexF); end
    checks++; if (pred_indexF !== 10'h2FE) begin errors++; $display("FAIL gshare_index got %h exp 2FE", pred_indexF); end
    tick();
  endtask

  task automatic test_stall_flush();
    logic [31:0] pc1, pc0;
    logic [9:0]  g;
    set_idle();
    pc1 = 32'((10'h0B0 ^ mGhr[9:0])) << 2;
    pc0 = 32'((10'h001 ^ mGhr[9:0])) << 2;
    g = mGhr[9:0];
    pcF = pc1; branchD = 1;
    #1;
    checks++; if (pred_takeF !== 1'b1) begin errors++; $display("FAIL sf_predF got %b exp 1", pred_takeF); end
    tick();
    checks++; if (pred_takeD !== 1'b1) begin errors++; $display("FAIL sf_load got %b exp 1", pred_takeD); end
    stallD = 1; pcF = pc0; branchF = 1;
    tick();
    checks++; if (pred_takeD !== 1'b1) begin errors++; $display("FAIL sf_hold got %b exp 1", pred_takeD); end
    checks++; if (ghr_snapF !== g) begin errors++; $display("FAIL sf_stall_ghr got %h exp %h", ghr_snapF, g); end
    stallD = 1; flushD = 1; pcF = pc1; branchF = 1;
    #1;
    checks++; if (pred_takeF !== 1'b1) begin errors++; $display("FAIL sf_both_predF got %b exp 1", pred_takeF); end
    tick();
    checks++; if (pred_takeD !== 1'b0) begin errors++; $display("FAIL sf_flush_wins got %b exp 0", pred_takeD); end
    checks++; if (ghr_snapF !== g) begin errors++; $display("FAIL sf_flush_ghr got %h exp %h", ghr_snapF, g); end
    stallD = 0; flushD = 0; branchF = 0;
    tick();
    branchD = 0;
    #1;
    checks++; if (pred_takeD !== 1'b0) begin errors++; $display("FAIL sf_branchD_gate got %b exp 0", pred_takeD); end
  endtask

  task automatic test_counter_sat();
    longint b0;
    set_idle();
    #1;
    force dut.mispred_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.mispred_cnt;
    mM = 64'hFFFF_FFFE;
    b0 = mB;
    branchM = 1; actual_takeM = 1; pred_takeM = 0; update_indexM = 10'h3FF; ghr_snapM = 10'h055;
    tick();
    checks++; if (mispred_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_first got %h exp FFFFFFFF", mispred_cnt); end
    tick(); tick();
    checks++; if (mispred_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_hold got %h exp FFFFFFFF", mispred_cnt); end
    checks++; if (branch_cnt !== 32'(b0 + 3)) begin errors++; $display("FAIL sat_bcnt got %h exp %h", branch_cnt, 32'(b0 + 3)); end
    set_idle();
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 299) == 0);
      stallD       = ($urandom_range(0, 5) == 0);
      flushD       = ($urandom_range(0, 7) == 0);
      branchF      = $urandom_range(0, 1);
      branchD      = $urandom_range(0, 1);
      branchM      = ($urandom_range(0, 2) != 0);
      actual_takeM = ($urandom_range(0, 3) != 0);
      pred_takeM   = ($urandom_range(0, 1) == 0) ? actual_takeM : ~actual_takeM;
      update_indexM = 10'($urandom_range(0, 63));
      ghr_snapM    = 10'($urandom_range(0, 1023));
      pcF = ($urandom() & 32'hFFFF_FF00) | (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
      #1;
      checks++; if (pred_indexF !== 10'(m_index(pcF))) begin errors++; $display("FAIL rnd_index n=%0d got %h exp %h", n, pred_indexF, 10'(m_index(pcF))); end
      checks++; if (pred_takeF !== m_pred(pcF)) begin errors++; $display("FAIL rnd_predF n=%0d got %b exp %b", n, pred_takeF, m_pred(pcF)); end
      checks++; if (ghr_snapF !== mGhr[9:0]) begin errors++; $display("FAIL rnd_ghr n=%0d got %h exp %h", n, ghr_snapF, mGhr[9:0]); end
      checks++; if (pred_takeD !== (branchD & mPtr)) begin errors++; $display("FAIL rnd_predD n=%0d got %b exp %b", n, pred_takeD, branchD & mPtr); end
      checks++; if (branch_cnt !== mB[31:0]) begin errors++; $display("FAIL rnd_bcnt n=%0d got %h exp %h", n, branch_cnt, mB[31:0]); end
      checks++; if (mispred_cnt !== mM[31:0]) begin errors++; $display("FAIL rnd_mcnt n=%0d got %h exp %h", n, mispred_cnt, mM[31:0]); end
      checks++; if (b_pred_indexF !== pcF[11:2]) begin errors++; $display("FAIL rnd_bimodal_index n=%0d got %h exp %h", n, b_pred_indexF, pcF[11:2]); end
      tick();
    end
    rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1;
    set_idle();
    test_reset();
    test_train();
    test_ghr_mispred_priority();
    test_mode_index();
    test_stall_flush();
    test_counter_sat();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
